// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// The edge indices assume 8x oversampling of the bit period.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } rx_state_t;

    // Checkers and the deserializer act one edge before the bit ends,
    // so their result is ready for the state decision on the last edge.
    localparam logic [2:0] SAMPLE_CHK_EDGE = 3'd6;
    localparam logic [2:0] LAST_EDGE       = 3'd7;

endpackage

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer: drives the edge/bit counter, sampler,
// deserializer and bit checkers, and reports the result of each frame.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line idle; a low rx_in starts the counter and enters START
// ST_START  | start bit; glitch check on edge 6, abort or continue on 7
// ST_DATA   | DATA_WIDTH data bits, one deserializer shift per bit
// ST_PARITY | optional parity bit; parity result captured on edge 7
// ST_STOP   | stop bit; stop result captured on edge 7
// ST_DONE   | single-cycle result report; low rx_in chains the next frame
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    input  logic       par_en,
    input  logic [2:0] edge_cnt,
    input  logic [3:0] bit_cnt,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic       cnt_enable,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_err_flag,
    output logic       stp_err_flag
);

    // Start bit is bit 0, so the last data bit index equals the width.
    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    rx_state_t state;
    logic      par_err_q;
    logic      stp_err_q;
    logic      last_edge;
    logic      chk_edge;

    assign last_edge = (edge_cnt == LAST_EDGE);
    assign chk_edge  = (edge_cnt == SAMPLE_CHK_EDGE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!rx_in)
                        state <= ST_START;
                end
                ST_START: begin
                    if (last_edge)
                        state <= strt_glitch ? ST_IDLE : ST_DATA;
                end
                ST_DATA: begin
                    if (last_edge && (bit_cnt == LAST_DATA_BIT))
                        state <= par_en ? ST_PARITY : ST_STOP;
                end
                ST_PARITY: begin
                    if (last_edge) begin
                        par_err_q <= par_err;
                        state     <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (last_edge) begin
                        stp_err_q <= stp_err;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    par_err_q <= 1'b0;
                    stp_err_q <= 1'b0;
                    state     <= rx_in ? ST_IDLE : ST_START;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Counter enable in IDLE/DONE follows rx_in directly so the counter
    // is already at edge 1 when START is entered.
    always_comb begin
        cnt_enable   = 1'b0;
        dat_samp_en  = 1'b0;
        deser_en     = 1'b0;
        strt_chk_en  = 1'b0;
        par_chk_en   = 1'b0;
        stp_chk_en   = 1'b0;
        data_valid   = 1'b0;
        par_err_flag = 1'b0;
        stp_err_flag = 1'b0;
        case (state)
            ST_IDLE: begin
                cnt_enable = !rx_in;
            end
            ST_START: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                strt_chk_en = chk_edge;
            end
            ST_DATA: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                deser_en    = chk_edge;
            end
            ST_PARITY: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                par_chk_en  = chk_edge;
            end
            ST_STOP: begin
                cnt_enable  = 1'b1;
                dat_samp_en = 1'b1;
                stp_chk_en  = chk_edge;
            end
            ST_DONE: begin
                cnt_enable   = !rx_in;
                data_valid   = !par_err_q && !stp_err_q;
                par_err_flag = par_err_q;
                stp_err_flag = stp_err_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural edge/bit counter
// and a shift-register model of the deserializer.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic [2:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       cnt_enable;
    logic       dat_samp_en;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       par_err_flag;
    logic       stp_err_flag;

    int checks   = 0;
    int failures = 0;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .par_en      (par_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .cnt_enable  (cnt_enable),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .strt_chk_en (strt_chk_en),
        .par_chk_en  (par_chk_en),
        .stp_chk_en  (stp_chk_en),
        .data_valid  (data_valid),
        .par_err_flag(par_err_flag),
        .stp_err_flag(stp_err_flag)
    );

    always #5 clk = ~clk;

    // Edge/bit counter: bit index wraps to 0 after the stop bit so a
    // chained frame starts from bit 0.
    logic [3:0] last_bit;
    assign last_bit = par_en ? 4'd10 : 4'd9;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt <= 3'd0;
            bit_cnt  <= 4'd0;
        end else if (!cnt_enable) begin
            edge_cnt <= 3'd0;
            bit_cnt  <= 4'd0;
        end else if (edge_cnt == 3'd7) begin
            edge_cnt <= 3'd0;
            bit_cnt  <= (bit_cnt == last_bit) ? 4'd0 : bit_cnt + 4'd1;
        end else begin
            edge_cnt <= edge_cnt + 3'd1;
        end
    end

    logic stream [0:399];

    int         dv_cnt, dv_first, dv_second;
    int         deser_cnt, deser_off;
    logic [7:0] word;
    int         strt_cnt, strt_first;
    int         par_chk_cnt, par_chk_first;
    int         stp_chk_cnt, stp_chk_first;
    int         pef_cnt, pef_first;
    int         sef_cnt, sef_first;
    int         samp_cnt, samp_in_rst;
    logic [1:0] probe;
    logic [8:0] snap;

    function automatic void fill_idle();
        for (int i = 0; i < 400; i++) stream[i] = 1'b1;
    endfunction

    function automatic void load_frame(input int off, input logic [7:0] d, input bit pen);
        int   nbits;
        logic v;
        nbits = pen ? 11 : 10;
        for (int b = 0; b < nbits; b++) begin
            if (b == 0)             v = 1'b0;
            else if (b <= 8)        v = d[b-1];
            else if (pen && b == 9) v = ^d;
            else                    v = 1'b1;
            for (int e = 0; e < 8; e++) stream[off + 8*b + e] = v;
        end
    endfunction

    // Drives the stream cycle by cycle and records what the DUT did.
    task automatic run(input int ncyc, input int glitch_at, input int perr_at,
                       input int serr_at, input int rst_at, input int rst_len,
                       input int probe_at, input bit perr_always);
        dv_cnt = 0; dv_first = -1; dv_second = -1;
        deser_cnt = 0; deser_off = 0; word = 8'h00;
        strt_cnt = 0; strt_first = -1;
        par_chk_cnt = 0; par_chk_first = -1;
        stp_chk_cnt = 0; stp_chk_first = -1;
        pef_cnt = 0; pef_first = -1;
        sef_cnt = 0; sef_first = -1;
        samp_cnt = 0; samp_in_rst = 0;
        probe = 2'bxx; snap = 'x;
        for (int k = 0; k < ncyc; k++) begin
            rx_in       = stream[k];
            strt_glitch = (k == glitch_at);
            par_err     = perr_always || (k == perr_at);
            stp_err     = (k == serr_at);
            if (k == rst_at) rst = 1'b0;
            if (rst_at >= 0 && k == rst_at + rst_len) rst = 1'b1;
            @(negedge clk);
            if (data_valid) begin
                dv_cnt++;
                if (dv_first < 0) dv_first = k;
                else if (dv_second < 0) dv_second = k;
            end
            if (deser_en) begin
                deser_cnt++;
                word = {rx_in, word[7:1]};
                if (edge_cnt != 3'd6) deser_off++;
            end
            if (strt_chk_en) begin strt_cnt++;    if (strt_first < 0)    strt_first = k;    end
            if (par_chk_en)  begin par_chk_cnt++; if (par_chk_first < 0) par_chk_first = k; end
            if (stp_chk_en)  begin stp_chk_cnt++; if (stp_chk_first < 0) stp_chk_first = k; end
            if (par_err_flag) begin pef_cnt++; if (pef_first < 0) pef_first = k; end
            if (stp_err_flag) begin sef_cnt++; if (sef_first < 0) sef_first = k; end
            if (dat_samp_en) samp_cnt++;
            if (!rst && dat_samp_en) samp_in_rst++;
            if (k == probe_at) probe = {cnt_enable, dat_samp_en};
            if (k == rst_at)
                snap = {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                        stp_chk_en, data_valid, par_err_flag, stp_err_flag};
            @(posedge clk);
            #1;
        end
        rx_in = 1'b1; strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [8:0] outs;
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        #2 rst = 1'b0;
        #1;
        outs = {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid, par_err_flag, stp_err_flag};
        checks++;
        if (outs !== 9'h000) begin
            failures++; $display("FAIL reset_outs_rx_high got=%b exp=%b", outs, 9'h000);
        end
        rx_in = 1'b0;
        #1;
        outs = {cnt_enable, dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid, par_err_flag, stp_err_flag};
        checks++;
        if (outs !== 9'h100) begin
            failures++; $display("FAIL reset_outs_rx_low got=%b exp=%b", outs, 9'h100);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cnt_enable, dat_samp_en} !== 2'b10) begin
            failures++; $display("FAIL reset_held_idle got=%b exp=10", {cnt_enable, dat_samp_en});
        end
        rx_in = 1'b1;
        @(posedge clk); #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_frame_55();
        par_en = 1'b0;
        fill_idle(); load_frame(0, 8'h55, 1'b0);
        run(100, -1, -1, -1, -1, 0, 0, 1'b0);
        checks++; if (probe !== 2'b10)  begin failures++; $display("FAIL f55_idle_cnt_en got=%b exp=10", probe); end
        checks++; if (deser_cnt !== 8)  begin failures++; $display("FAIL f55_deser_cnt got=%0d exp=8", deser_cnt); end
        checks++; if (deser_off !== 0)  begin failures++; $display("FAIL f55_deser_edge got=%0d exp=0", deser_off); end
        checks++; if (word !== 8'h55)   begin failures++; $display("FAIL f55_word got=%h exp=55", word); end
        checks++; if (dv_cnt !== 1)     begin failures++; $display("FAIL f55_dv_cnt got=%0d exp=1", dv_cnt); end
        checks++; if (dv_first !== 80)  begin failures++; $display("FAIL f55_dv_cycle got=%0d exp=80", dv_first); end
        checks++; if (strt_first !== 6) begin failures++; $display("FAIL f55_strt_chk got=%0d exp=6", strt_first); end
        checks++; if (stp_chk_first !== 78) begin failures++; $display("FAIL f55_stp_chk got=%0d exp=78", stp_chk_first); end
        checks++; if (par_chk_cnt !== 0) begin failures++; $display("FAIL f55_par_chk got=%0d exp=0", par_chk_cnt); end
        checks++; if (pef_cnt + sef_cnt !== 0) begin failures++; $display("FAIL f55_flags got=%0d exp=0", pef_cnt + sef_cnt); end
        checks++; if (samp_cnt !== 79)  begin failures++; $display("FAIL f55_samp_cycles got=%0d exp=79", samp_cnt); end
    endtask

    task automatic test_glitch();
        par_en = 1'b0;
        fill_idle();
        for (int i = 0; i < 3; i++) stream[i] = 1'b0;
        run(30, 7, -1, -1, -1, 0, 8, 1'b0);
        checks++; if (probe !== 2'b00)  begin failures++; $display("FAIL glitch_idle_at_8 got=%b exp=00", probe); end
        checks++; if (deser_cnt !== 0)  begin failures++; $display("FAIL glitch_deser got=%0d exp=0", deser_cnt); end
        checks++; if (dv_cnt !== 0)     begin failures++; $display("FAIL glitch_dv got=%0d exp=0", dv_cnt); end
        checks++; if (strt_cnt !== 1)   begin failures++; $display("FAIL glitch_strt_chk got=%0d exp=1", strt_cnt); end
        checks++; if (samp_cnt !== 7)   begin failures++; $display("FAIL glitch_samp got=%0d exp=7", samp_cnt); end
        checks++; if (stp_chk_cnt !== 0) begin failures++; $display("FAIL glitch_stp_chk got=%0d exp=0", stp_chk_cnt); end
    endtask

    task automatic test_parity_err();
        par_en = 1'b1;
        fill_idle(); load_frame(0, 8'hA3, 1'b1);
        run(100, -1, 79, -1, -1, 0, -1, 1'b0);
        checks++; if (dv_cnt !== 0)     begin failures++; $display("FAIL par_dv got=%0d exp=0", dv_cnt); end
        checks++; if (pef_cnt !== 1)    begin failures++; $display("FAIL par_flag_cnt got=%0d exp=1", pef_cnt); end
        checks++; if (pef_first !== 88) begin failures++; $display("FAIL par_done_cycle got=%0d exp=88", pef_first); end
        checks++; if (sef_cnt !== 0)    begin failures++; $display("FAIL par_stp_flag got=%0d exp=0", sef_cnt); end
        checks++; if (par_chk_first !== 78) begin failures++; $display("FAIL par_chk_cycle got=%0d exp=78", par_chk_first); end
        checks++; if (stp_chk_first !== 86) begin failures++; $display("FAIL par_stp_chk got=%0d exp=86", stp_chk_first); end
        checks++; if (word !== 8'hA3)   begin failures++; $display("FAIL par_word got=%h exp=a3", word); end
    endtask

    task automatic test_stop_err();
        par_en = 1'b0;
        fill_idle(); load_frame(0, 8'h0F, 1'b0);
        run(100, -1, -1, 79, -1, 0, -1, 1'b1);
        checks++; if (dv_cnt !== 0)     begin failures++; $display("FAIL stp_dv got=%0d exp=0", dv_cnt); end
        checks++; if (sef_cnt !== 1)    begin failures++; $display("FAIL stp_flag_cnt got=%0d exp=1", sef_cnt); end
        checks++; if (sef_first !== 80) begin failures++; $display("FAIL stp_done_cycle got=%0d exp=80", sef_first); end
        checks++; if (pef_cnt !== 0)    begin failures++; $display("FAIL stp_par_flag got=%0d exp=0", pef_cnt); end
        checks++; if (par_chk_cnt !== 0) begin failures++; $display("FAIL stp_par_chk got=%0d exp=0", par_chk_cnt); end
    endtask

    task automatic test_back_to_back();
        par_en = 1'b0;
        fill_idle(); load_frame(0, 8'h3C, 1'b0); load_frame(80, 8'hC5, 1'b0);
        run(180, -1, -1, -1, -1, 0, 81, 1'b0);
        checks++; if (dv_cnt !== 2)      begin failures++; $display("FAIL b2b_dv_cnt got=%0d exp=2", dv_cnt); end
        checks++; if (dv_first !== 80)   begin failures++; $display("FAIL b2b_dv1 got=%0d exp=80", dv_first); end
        checks++; if (dv_second !== 160) begin failures++; $display("FAIL b2b_dv2 got=%0d exp=160", dv_second); end
        checks++; if (deser_cnt !== 16)  begin failures++; $display("FAIL b2b_deser got=%0d exp=16", deser_cnt); end
        checks++; if (word !== 8'hC5)    begin failures++; $display("FAIL b2b_word got=%h exp=c5", word); end
        checks++; if (probe !== 2'b11)   begin failures++; $display("FAIL b2b_start_at_81 got=%b exp=11", probe); end
        checks++; if (strt_cnt !== 2)    begin failures++; $display("FAIL b2b_strt_chk got=%0d exp=2", strt_cnt); end
    endtask

    task automatic test_reset_mid();
        par_en = 1'b0;
        fill_idle(); load_frame(0, 8'h96, 1'b0);
        for (int i = 36; i < 50; i++) stream[i] = 1'b1;
        load_frame(50, 8'h69, 1'b0);
        run(150, -1, -1, -1, 36, 4, -1, 1'b0);
        checks++; if (snap !== 9'h000)   begin failures++; $display("FAIL rstmid_outs got=%b exp=%b", snap, 9'h000); end
        checks++; if (samp_in_rst !== 0) begin failures++; $display("FAIL rstmid_samp got=%0d exp=0", samp_in_rst); end
        checks++; if (dv_cnt !== 1)      begin failures++; $display("FAIL rstmid_dv_cnt got=%0d exp=1", dv_cnt); end
        checks++; if (dv_first !== 130)  begin failures++; $display("FAIL rstmid_dv_cycle got=%0d exp=130", dv_first); end
        checks++; if (pef_cnt + sef_cnt !== 0) begin failures++; $display("FAIL rstmid_flags got=%0d exp=0", pef_cnt + sef_cnt); end
        checks++; if (deser_cnt !== 11)  begin failures++; $display("FAIL rstmid_deser got=%0d exp=11", deser_cnt); end
        checks++; if (word !== 8'h69)    begin failures++; $display("FAIL rstmid_word got=%h exp=69", word); end
    endtask

    initial begin
        test_reset();
        test_frame_55();
        test_glitch();
        test_parity_err();
        test_stop_err();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
